tt_sweep_checker: RTL and testbench

Sequential truth-table sweeper placed directly upstream of a synthesized 4-input NOR/NOT gate netlist; it also observes that gate's output. It drives all 16 input rows into the gate under test, waits a programmable settle time per row, samples the single-bit response, and assembles the 16-bit truth-table word. The word is compared against an expected table, default 16'hD4E4, and pass/fail plus diagnostics are reported. It is the self-check harness stage for yosys-mapped gate netlists in the design-generation flow.

---
 rtl/tt_sweep_pkg.sv | 23 ++
 rtl/tt_sweep_checker_compare.sv | 42 ++++
 rtl/tt_sweep_checker.sv | 138 +++++++++++++
 tb/tb_tt_sweep_checker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// ----------------------------------------------------------------------------
// tt_sweep_pkg
// Shared definitions for the truth-table sweep checker:
//   ROWS / TT_W : number of input rows and width of the truth-table word
//   state_e     : sweep FSM states
//   TT_D4E4     : default golden truth table of the NOR/NOT gate under test
// ----------------------------------------------------------------------------
package tt_sweep_pkg;

    localparam int ROWS = 16;
    localparam int TT_W = 16;

    // Bit (15-r) holds the gate output for row r = {_0,_1,_2,_3}.
    localparam logic [TT_W-1:0] TT_D4E4 = 16'hD4E4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage : tt_sweep_pkg

// File: rtl/tt_sweep_checker_compare.sv
// ----------------------------------------------------------------------------
// tt_result_compare
// Combinational comparison of a captured truth table against the golden one.
//   tt         in  16  captured truth table (bit 15-r = row r)
//   mismatch   out 16  tt ^ EXPECTED_TT
//   pass       out 1   no mismatching row
//   first_fail out 4   lowest row index whose bit mismatches, 0 when pass
// ----------------------------------------------------------------------------
module tt_result_compare
    import tt_sweep_pkg::*;
#(
    parameter logic [TT_W-1:0] EXPECTED_TT = TT_D4E4
) (
    input  logic [TT_W-1:0] tt,
    output logic [TT_W-1:0] mismatch,
    output logic            pass,
    output logic [3:0]      first_fail
);

    logic [TT_W-1:0] diff_s;

    // Difference word and pass flag.
    always_comb begin
        diff_s   = tt ^ EXPECTED_TT;
        mismatch = diff_s;
        pass     = (diff_s == {TT_W{1'b0}});
    end

    // Priority encoder: scan from the highest row down so the lowest
    // mismatching row is the last (winning) assignment.
    always_comb begin
        first_fail = 4'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (diff_s[TT_W-1-r]) begin
                first_fail = 4'(r);
            end else begin
                first_fail = first_fail;
            end
        end
    end

endmodule : tt_result_compare

// File: rtl/tt_sweep_checker.sv
// ----------------------------------------------------------------------------
// tt_sweep_checker
// Drives all 16 rows into a 4-input gate, holds each row SETTLE cycles,
// samples the gate output, builds the truth-table word and compares it
// against EXPECTED_TT.
//   clk        in  1   rising-edge clock
//   rst        in  1   synchronous active-high reset
//   start      in  1   sweep request, honoured only when idle
//   stim_o     out 4   row driven to the gate ({_0,_1,_2,_3})
//   dut_i      in  1   gate output (already synchronous to clk)
//   busy       out 1   sweep in progress (through the done cycle)
//   done       out 1   one-cycle pulse, results valid from this cycle
//   tt_word    out 16  captured truth table
//   mismatch   out 16  tt_word ^ EXPECTED_TT
//   pass       out 1   mismatch == 0
//   first_fail out 4   lowest failing row, 0 when pass
// ----------------------------------------------------------------------------
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter logic [TT_W-1:0] EXPECTED_TT = TT_D4E4,
    parameter int unsigned     SETTLE      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [3:0]      stim_o,
    input  logic            dut_i,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_word,
    output logic [TT_W-1:0] mismatch,
    output logic            pass,
    output logic [3:0]      first_fail
);

    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    state_e          state_r,  state_nxt_s;
    logic [3:0]      row_r,    row_nxt_s;
    logic [7:0]      cnt_r,    cnt_nxt_s;
    logic [TT_W-1:0] shift_r,  shift_nxt_s;
    logic            capture_s;

    logic [TT_W-1:0] cmp_mismatch_s;
    logic            cmp_pass_s;
    logic [3:0]      cmp_first_fail_s;

    // Next-state logic for the sweep FSM, row/settle counters and shift reg.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    row_nxt_s   = 4'd0;
                    cnt_nxt_s   = 8'd0;
                    shift_nxt_s = {TT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_nxt_s = cnt_r + 8'd1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                // Row 0 shifts in first and ends up in bit 15.
                shift_nxt_s = {shift_r[TT_W-2:0], dut_i};
                if (row_r == 4'd15) begin
                    state_nxt_s = ST_DONE;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_SETTLE;
                    row_nxt_s   = row_r + 4'd1;
                    cnt_nxt_s   = 8'd0;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Compare against the word being captured so results land with done.
    tt_result_compare #(
        .EXPECTED_TT (EXPECTED_TT)
    ) u_compare (
        .tt         (shift_nxt_s),
        .mismatch   (cmp_mismatch_s),
        .pass       (cmp_pass_s),
        .first_fail (cmp_first_fail_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            row_r      <= 4'd0;
            cnt_r      <= 8'd0;
            shift_r    <= {TT_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            tt_word    <= {TT_W{1'b0}};
            mismatch   <= {TT_W{1'b0}};
            pass       <= 1'b0;
            first_fail <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shift_r <= shift_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
            done    <= capture_s;
            // Results persist until the next capture; a new start keeps them.
            if (capture_s) begin
                tt_word    <= shift_nxt_s;
                mismatch   <= cmp_mismatch_s;
                pass       <= cmp_pass_s;
                first_fail <= cmp_first_fail_s;
            end
        end
    end

    assign stim_o = row_r;

endmodule : tt_sweep_checker

// File: tb/tb_tt_sweep_checker.sv
// ----------------------------------------------------------------------------
// tb_tt_sweep_checker
// Directed bench: u0 uses SETTLE=2, u1 uses SETTLE=1. The gate under test is
// a behavioural model of the 4-input network, with fault modes selectable.
// ----------------------------------------------------------------------------
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [3:0]  stim0, stim1;
    logic        dut_i0, dut_i1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] tt0, tt1, mm0, mm1;
    logic [3:0]  ff0, ff1;
    int          mode;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;

    always #5 clk = ~clk;

    // Gate model: row = {_0,_1,_2,_3}; mode 0 golden, 1 stuck-at-0,
    // 2 inverted, 3 row 5 flipped.
    function automatic logic gate_model(input logic [3:0] row, input int m);
        logic a, b, c, d, g;
        a = row[3]; b = row[2]; c = row[1]; d = row[0];
        g = b ? ~(c | ~d) : (a ? ~(c & d) : (~c | d));
        case (m)
            0:       return g;
            1:       return 1'b0;
            2:       return ~g;
            3:       return (row == 4'd5) ? ~g : g;
            default: return g;
        endcase
    endfunction

    assign dut_i0 = gate_model(stim0, mode);
    assign dut_i1 = gate_model(stim1, mode);

    tt_sweep_checker #(.EXPECTED_TT(16'hD4E4), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .stim_o(stim0), .dut_i(dut_i0),
        .busy(busy0), .done(done0), .tt_word(tt0), .mismatch(mm0),
        .pass(pass0), .first_fail(ff0)
    );

    tt_sweep_checker #(.EXPECTED_TT(16'hD4E4), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stim_o(stim1), .dut_i(dut_i1),
        .busy(busy1), .done(done1), .tt_word(tt1), .mismatch(mm1),
        .pass(pass1), .first_fail(ff1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on u0 and count cycles from acceptance until done.
    task automatic sweep0(output int c);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        c = 0;
        check("busy0_after_start", {31'd0, busy0}, 32'd1);
        while (done0 !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        logic [3:0] exp_stim;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check("rst_stim",  {28'd0, stim0}, 32'd0);
        check("rst_busy",  {31'd0, busy0}, 32'd0);
        check("rst_done",  {31'd0, done0}, 32'd0);
        check("rst_tt",    {16'd0, tt0},   32'd0);
        check("rst_mm",    {16'd0, mm0},   32'd0);
        check("rst_pass",  {31'd0, pass0}, 32'd0);
        check("rst_ff",    {28'd0, ff0},   32'd0);
        rst = 1'b0;

        // Golden gate
        mode = 0;
        sweep0(cyc);
        check("gold_latency", cyc,           32'd48);
        check("gold_tt",      {16'd0, tt0},  32'h0000D4E4);
        check("gold_mm",      {16'd0, mm0},  32'd0);
        check("gold_pass",    {31'd0, pass0}, 32'd1);
        check("gold_ff",      {28'd0, ff0},  32'd0);
        check("gold_busy",    {31'd0, busy0}, 32'd1);
        @(negedge clk);
        check("gold_done_pulse", {31'd0, done0}, 32'd0);
        check("gold_idle_busy",  {31'd0, busy0}, 32'd0);
        check("gold_stim_hold",  {28'd0, stim0}, 32'd15);

        // Stuck-at-0 output
        mode = 1;
        sweep0(cyc);
        check("s0_latency", cyc,            32'd48);
        check("s0_tt",      {16'd0, tt0},   32'd0);
        check("s0_mm",      {16'd0, mm0},   32'h0000D4E4);
        check("s0_pass",    {31'd0, pass0}, 32'd0);
        check("s0_ff",      {28'd0, ff0},   32'd0);

        // Inverted gate
        mode = 2;
        sweep0(cyc);
        check("inv_tt",   {16'd0, tt0},   32'h00002B1B);
        check("inv_mm",   {16'd0, mm0},   32'h0000FFFF);
        check("inv_pass", {31'd0, pass0}, 32'd0);
        check("inv_ff",   {28'd0, ff0},   32'd0);

        // Single-row fault on row 5
        mode = 3;
        sweep0(cyc);
        check("r5_tt",   {16'd0, tt0},   32'h0000D0E4);
        check("r5_mm",   {16'd0, mm0},   32'h00000400);
        check("r5_pass", {31'd0, pass0}, 32'd0);
        check("r5_ff",   {28'd0, ff0},   32'd5);

        // SETTLE=1 stimulus timing, with a start pulse while busy
        mode = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int n = 0; n < 32; n++) begin
            exp_stim = 4'(n / 2);
            check("s1_stim", {28'd0, stim1}, {28'd0, exp_stim});
            check("s1_busy", {31'd0, busy1}, 32'd1);
            check("s1_no_early_done", {31'd0, done1}, 32'd0);
            start1 = (n == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start1 = 1'b0;
        check("s1_done_at_32", {31'd0, done1}, 32'd1);
        check("s1_tt",         {16'd0, tt1},   32'h0000D4E4);
        check("s1_pass",       {31'd0, pass1}, 32'd1);
        repeat (3) @(negedge clk);
        check("s1_hold_done", {31'd0, done1}, 32'd0);
        check("s1_hold_busy", {31'd0, busy1}, 32'd0);
        check("s1_hold_tt",   {16'd0, tt1},   32'h0000D4E4);

        // New sweep keeps the old results until its own done
        mode = 1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (5) @(negedge clk);
        check("s1_keep_tt",   {16'd0, tt1},   32'h0000D4E4);
        check("s1_keep_pass", {31'd0, pass1}, 32'd1);
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("s1_second_done", {31'd0, done1}, 32'd1);
        check("s1_second_tt",   {16'd0, tt1},   32'd0);
        check("s1_second_pass", {31'd0, pass1}, 32'd0);

        // Reset in the middle of a sweep
        mode = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        cyc = 0;
        while (stim0 !== 4'd7 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_row7", {28'd0, stim0}, 32'd7);
        rst = 1'b1;
        @(negedge clk);
        check("mid_stim", {28'd0, stim0}, 32'd0);
        check("mid_busy", {31'd0, busy0}, 32'd0);
        check("mid_done", {31'd0, done0}, 32'd0);
        check("mid_tt",   {16'd0, tt0},   32'd0);
        check("mid_mm",   {16'd0, mm0},   32'd0);
        check("mid_pass", {31'd0, pass0}, 32'd0);
        check("mid_ff",   {28'd0, ff0},   32'd0);
        rst = 1'b0;
        sweep0(cyc);
        check("post_rst_latency", cyc,           32'd48);
        check("post_rst_tt",      {16'd0, tt0},  32'h0000D4E4);
        check("post_rst_pass",    {31'd0, pass0}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tt_sweep_checker
